operand_addr_seq: RTL and testbench

- Parametrised successor to the fixed three-operand read-address FSM.
- Accepts one micro-instruction carrying NUM_SRC source register addresses, an operand-enable mask, a pair-read flag and an opcode.
- Emits one read-address beat per enabled operand, plus an optional trailing pair beat, on a valid/ready channel toward the register-file read port.
- Forwards the opcode once per instruction on a separate valid/ready channel to the opcode FIFO.

---
 rtl/operand_addr_seq_pkg.sv | 18 +
 rtl/operand_addr_seq_next_operand_sel.sv | 36 +++
 rtl/operand_addr_seq.sv | 205 ++++++++++++++++++++
 tb/tb_operand_addr_seq.sv | 347 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/operand_addr_seq_pkg.sv
// Shared types and default sizing for the operand read-address sequencer.
package config_pkg;

    localparam int NUM_SRC_DEF = 4;
    localparam int ADDR_W_DEF  = 5;
    localparam int CODE_W_DEF  = 8;

    typedef logic [ADDR_W_DEF-1:0]  addr_t;
    typedef logic [CODE_W_DEF-1:0]  code_t;
    typedef logic [NUM_SRC_DEF-1:0] src_mask_t;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_ISSUE     = 2'd1,
        ST_CODE_WAIT = 2'd2
    } opseq_state_e;

endpackage

// File: rtl/operand_addr_seq_next_operand_sel.sv
// Find-next-set-bit helper: the lowest enabled slot above idx (or from slot 0
// when from_start is set), plus the highest enabled slot in the mask.
module next_operand_sel #(
    parameter int NUM_SRC = 4,
    parameter int IDX_W   = $clog2(NUM_SRC + 1)
) (
    input  logic [NUM_SRC-1:0] mask,
    input  logic [IDX_W-1:0]   idx,
    input  logic               from_start,
    output logic [IDX_W-1:0]   next_idx,
    output logic               found,
    output logic [IDX_W-1:0]   high_idx
);

    // Priority scan upward: the first qualifying bit wins, the last set bit is the highest.
    always_comb begin
        next_idx = {IDX_W{1'b0}};
        found    = 1'b0;
        high_idx = {IDX_W{1'b0}};
        for (int k = 0; k < NUM_SRC; k++) begin
            if (mask[k] && !found && (from_start || (IDX_W'(k) > idx))) begin
                next_idx = IDX_W'(k);
                found    = 1'b1;
            end else begin
                next_idx = next_idx;
                found    = found;
            end
            if (mask[k]) begin
                high_idx = IDX_W'(k);
            end else begin
                high_idx = high_idx;
            end
        end
    end

endmodule

// File: rtl/operand_addr_seq.sv
// Operand read-address sequencer: one beat per enabled source slot, an optional
// trailing pair beat, and the opcode forwarded once on its own channel.
module operand_addr_seq
    import config_pkg::*;
#(
    parameter int NUM_SRC = NUM_SRC_DEF,
    parameter int ADDR_W  = ADDR_W_DEF,
    parameter int CODE_W  = CODE_W_DEF,
    localparam int IDX_W  = $clog2(NUM_SRC + 1)
) (
    input  logic                      clk_i,
    input  logic                      arst_ni,
    input  logic [NUM_SRC*ADDR_W-1:0] uinstr_addr_i,
    input  logic [NUM_SRC-1:0]        uinstr_mask_i,
    input  logic                      uinstr_pair_i,
    input  logic [CODE_W-1:0]         uinstr_code_i,
    input  logic                      uinstr_valid_i,
    output logic                      uinstr_ready_o,
    output logic [ADDR_W-1:0]         rd_addr_o,
    output logic [IDX_W-1:0]          rd_idx_o,
    output logic                      rd_last_o,
    output logic                      rd_addr_valid_o,
    input  logic                      rd_addr_ready_i,
    output logic [CODE_W-1:0]         code_o,
    output logic                      code_valid_o,
    input  logic                      code_ready_i
);

    // Beat pointer value that selects the trailing pair beat.
    localparam logic [IDX_W-1:0] PAIR_IDX = IDX_W'(NUM_SRC);

    opseq_state_e              state_r, state_n_s;
    logic [NUM_SRC*ADDR_W-1:0] addr_r, addr_n_s;
    logic [NUM_SRC-1:0]        mask_r, mask_n_s;
    logic                      pair_r, pair_n_s;
    logic [CODE_W-1:0]         code_r, code_n_s;
    logic                      code_pending_r, code_pending_n_s;
    logic [IDX_W-1:0]          ptr_r, ptr_n_s;
    logic [ADDR_W-1:0]         pair_addr_r, pair_addr_n_s;

    logic [IDX_W-1:0]  nxt_idx_s, cur_high_s, first_idx_s, new_high_s;
    logic              nxt_found_s, first_found_s;
    logic [ADDR_W-1:0] slot_addr_s, new_high_addr_s;
    logic              last_s, beat_hs_s, code_hs_s, code_done_s, ready_s, accept_s;

    next_operand_sel #(.NUM_SRC(NUM_SRC), .IDX_W(IDX_W)) u_sel_cur (
        .mask       (mask_r),
        .idx        (ptr_r),
        .from_start (1'b0),
        .next_idx   (nxt_idx_s),
        .found      (nxt_found_s),
        .high_idx   (cur_high_s)
    );

    next_operand_sel #(.NUM_SRC(NUM_SRC), .IDX_W(IDX_W)) u_sel_new (
        .mask       (uinstr_mask_i),
        .idx        ({IDX_W{1'b0}}),
        .from_start (1'b1),
        .next_idx   (first_idx_s),
        .found      (first_found_s),
        .high_idx   (new_high_s)
    );

    // Select the current slot address and the highest address of the incoming instruction.
    always_comb begin
        slot_addr_s     = {ADDR_W{1'b0}};
        new_high_addr_s = {ADDR_W{1'b0}};
        for (int k = 0; k < NUM_SRC; k++) begin
            if (ptr_r == IDX_W'(k)) begin
                slot_addr_s = addr_r[k*ADDR_W +: ADDR_W];
            end else begin
                slot_addr_s = slot_addr_s;
            end
            if (new_high_s == IDX_W'(k)) begin
                new_high_addr_s = uinstr_addr_i[k*ADDR_W +: ADDR_W];
            end else begin
                new_high_addr_s = new_high_addr_s;
            end
        end
    end

    // Handshake decode; instruction ready frees up in the cycle the old one completes.
    always_comb begin
        last_s      = (ptr_r == PAIR_IDX) | (!pair_r & (ptr_r == cur_high_s));
        beat_hs_s   = (state_r == ST_ISSUE) & rd_addr_ready_i;
        code_hs_s   = (state_r != ST_IDLE) & code_pending_r & code_ready_i;
        code_done_s = !code_pending_r | code_hs_s;
        case (state_r)
            ST_IDLE:      ready_s = 1'b1;
            ST_ISSUE:     ready_s = beat_hs_s & last_s & code_done_s;
            ST_CODE_WAIT: ready_s = code_hs_s;
            default:      ready_s = 1'b0;
        endcase
        accept_s = uinstr_valid_i & ready_s & arst_ni;
    end

    // Next-state: advance beats, retire the code, then let a new accept override.
    always_comb begin
        state_n_s        = state_r;
        addr_n_s         = addr_r;
        mask_n_s         = mask_r;
        pair_n_s         = pair_r;
        code_n_s         = code_r;
        code_pending_n_s = code_pending_r;
        ptr_n_s          = ptr_r;
        pair_addr_n_s    = pair_addr_r;
        case (state_r)
            ST_IDLE: begin
                state_n_s = ST_IDLE;
            end
            ST_ISSUE: begin
                if (beat_hs_s) begin
                    if (last_s) begin
                        state_n_s = code_done_s ? ST_IDLE : ST_CODE_WAIT;
                    end else begin
                        ptr_n_s = nxt_found_s ? nxt_idx_s : PAIR_IDX;
                    end
                end else begin
                    state_n_s = ST_ISSUE;
                end
            end
            ST_CODE_WAIT: begin
                if (code_hs_s) begin
                    state_n_s = ST_IDLE;
                end else begin
                    state_n_s = ST_CODE_WAIT;
                end
            end
            default: begin
                state_n_s = ST_IDLE;
            end
        endcase
        if (code_hs_s) begin
            code_pending_n_s = 1'b0;
        end else begin
            code_pending_n_s = code_pending_n_s;
        end
        if (accept_s) begin
            addr_n_s         = uinstr_addr_i;
            mask_n_s         = uinstr_mask_i;
            pair_n_s         = uinstr_pair_i & first_found_s;
            code_n_s         = uinstr_code_i;
            code_pending_n_s = 1'b1;
            ptr_n_s          = first_idx_s;
            pair_addr_n_s    = new_high_addr_s + ADDR_W'(1);
            state_n_s        = first_found_s ? ST_ISSUE : ST_CODE_WAIT;
        end else begin
            state_n_s = state_n_s;
        end
    end

    // State and instruction registers with synchronous active-low reset.
    always_ff @(posedge clk_i) begin
        if (!arst_ni) begin
            state_r        <= ST_IDLE;
            addr_r         <= {(NUM_SRC*ADDR_W){1'b0}};
            mask_r         <= {NUM_SRC{1'b0}};
            pair_r         <= 1'b0;
            code_r         <= {CODE_W{1'b0}};
            code_pending_r <= 1'b0;
            ptr_r          <= {IDX_W{1'b0}};
            pair_addr_r    <= {ADDR_W{1'b0}};
        end else begin
            state_r        <= state_n_s;
            addr_r         <= addr_n_s;
            mask_r         <= mask_n_s;
            pair_r         <= pair_n_s;
            code_r         <= code_n_s;
            code_pending_r <= code_pending_n_s;
            ptr_r          <= ptr_n_s;
            pair_addr_r    <= pair_addr_n_s;
        end
    end

    // Output drive from registered state, forced to zero while reset is asserted.
    always_comb begin
        uinstr_ready_o  = 1'b0;
        rd_addr_o       = {ADDR_W{1'b0}};
        rd_idx_o        = {IDX_W{1'b0}};
        rd_last_o       = 1'b0;
        rd_addr_valid_o = 1'b0;
        code_o          = {CODE_W{1'b0}};
        code_valid_o    = 1'b0;
        if (arst_ni) begin
            uinstr_ready_o = ready_s;
            if (state_r == ST_ISSUE) begin
                rd_addr_valid_o = 1'b1;
                rd_addr_o       = (ptr_r == PAIR_IDX) ? pair_addr_r : slot_addr_s;
                rd_idx_o        = ptr_r;
                rd_last_o       = last_s;
            end else begin
                rd_addr_valid_o = 1'b0;
            end
            if (code_pending_r) begin
                code_valid_o = 1'b1;
                code_o       = code_r;
            end else begin
                code_valid_o = 1'b0;
            end
        end else begin
            uinstr_ready_o = 1'b0;
        end
    end

endmodule

// File: tb/tb_operand_addr_seq.sv
// Self-checking bench for operand_addr_seq (NUM_SRC=4, ADDR_W=5, CODE_W=8).
module tb_operand_addr_seq;

    localparam int NS = 4;
    localparam int AW = 5;

    logic          clk_i = 1'b0;
    logic          arst_ni;
    logic [19:0]   uinstr_addr_i;
    logic [3:0]    uinstr_mask_i;
    logic          uinstr_pair_i;
    logic [7:0]    uinstr_code_i;
    logic          uinstr_valid_i;
    logic          uinstr_ready_o;
    logic [4:0]    rd_addr_o;
    logic [2:0]    rd_idx_o;
    logic          rd_last_o;
    logic          rd_addr_valid_o;
    logic          rd_addr_ready_i;
    logic [7:0]    code_o;
    logic          code_valid_o;
    logic          code_ready_i;

    operand_addr_seq dut (
        .clk_i           (clk_i),
        .arst_ni         (arst_ni),
        .uinstr_addr_i   (uinstr_addr_i),
        .uinstr_mask_i   (uinstr_mask_i),
        .uinstr_pair_i   (uinstr_pair_i),
        .uinstr_code_i   (uinstr_code_i),
        .uinstr_valid_i  (uinstr_valid_i),
        .uinstr_ready_o  (uinstr_ready_o),
        .rd_addr_o       (rd_addr_o),
        .rd_idx_o        (rd_idx_o),
        .rd_last_o       (rd_last_o),
        .rd_addr_valid_o (rd_addr_valid_o),
        .rd_addr_ready_i (rd_addr_ready_i),
        .code_o          (code_o),
        .code_valid_o    (code_valid_o),
        .code_ready_i    (code_ready_i)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        int addr;
        int idx;
        int last;
        int cyc;
    } beat_t;

    typedef struct {
        int code;
        int cyc;
    } code_ev_t;

    int       pass_cnt = 0;
    int       chk_cnt  = 0;
    int       cyc      = 0;
    beat_t    mq[$];
    int       mcp      = 0;
    int       mcode    = 0;
    beat_t    beat_log[$];
    code_ev_t code_log[$];
    int       acc_log[$];

    task automatic check(input string name, input int act, input int exp);
        chk_cnt++;
        if (act == exp) pass_cnt++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    // Model: expand an accepted instruction into its ordered list of beats.
    task automatic build_beats(input logic [19:0] a, input logic [3:0] m, input logic p);
        int hi;
        logic [4:0] s;
        hi = -1;
        for (int k = 0; k < NS; k++) begin
            if (m[k]) begin
                s = a[k*AW +: AW];
                mq.push_back('{int'(s), k, 0, 0});
                hi = k;
            end
        end
        if (p && hi >= 0) begin
            s = a[hi*AW +: AW];
            mq.push_back('{(int'(s) + 1) % 32, NS, 0, 0});
        end
        if (mq.size() > 0) mq[mq.size()-1].last = 1;
    endtask

    // Compare process: every negedge, DUT outputs against the model.
    initial begin
        int nb;
        int e_ready;
        int z;
        forever begin
            @(negedge clk_i);
            cyc++;
            if (!arst_ni) begin
                z = int'(uinstr_ready_o | rd_addr_valid_o | code_valid_o | rd_last_o)
                    + int'(rd_addr_o) + int'(rd_idx_o) + int'(code_o);
                check("reset_outputs_zero", z, 0);
                mq.delete();
                mcp = 0;
            end else begin
                nb = mq.size();
                e_ready = int'((nb == 0 || (nb == 1 && rd_addr_ready_i)) && (mcp == 0 || code_ready_i));
                check("model_uinstr_ready", int'(uinstr_ready_o), e_ready);
                check("model_rd_valid", int'(rd_addr_valid_o), int'(nb > 0));
                check("model_code_valid", int'(code_valid_o), mcp);
                if (nb > 0) begin
                    check("model_rd_addr", int'(rd_addr_o), mq[0].addr);
                    check("model_rd_idx", int'(rd_idx_o), mq[0].idx);
                    check("model_rd_last", int'(rd_last_o), mq[0].last);
                    if (rd_addr_ready_i) begin
                        beat_log.push_back('{int'(rd_addr_o), int'(rd_idx_o), int'(rd_last_o), cyc});
                        void'(mq.pop_front());
                    end
                end
                if (mcp != 0) begin
                    check("model_code", int'(code_o), mcode);
                    if (code_ready_i) begin
                        code_log.push_back('{int'(code_o), cyc});
                        mcp = 0;
                    end
                end
                if (uinstr_valid_i && e_ready != 0) begin
                    acc_log.push_back(cyc);
                    build_beats(uinstr_addr_i, uinstr_mask_i, uinstr_pair_i);
                    mcp   = 1;
                    mcode = int'(uinstr_code_i);
                end
            end
        end
    end

    // Present one instruction; entered and left just after a rising edge.
    task automatic send(input logic [19:0] a, input logic [3:0] m, input logic p, input logic [7:0] c);
        int n;
        n = 0;
        uinstr_addr_i  = a;
        uinstr_mask_i  = m;
        uinstr_pair_i  = p;
        uinstr_code_i  = c;
        uinstr_valid_i = 1'b1;
        do begin
            @(negedge clk_i);
            n++;
        end while (!uinstr_ready_o && n < 60);
        if (!uinstr_ready_o) check("accept_timeout", 0, 1);
        @(posedge clk_i);
        #1;
        uinstr_valid_i = 1'b0;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        do begin
            @(negedge clk_i);
            n++;
        end while ((rd_addr_valid_o || code_valid_o) && n < 60);
        if (n >= 60) check("idle_timeout", 0, 1);
        @(posedge clk_i);
        #1;
    endtask

    task automatic clear_logs();
        beat_log.delete();
        code_log.delete();
        acc_log.delete();
    endtask

    // Slot packing: slot0=3, slot1=7, slot2=9, slot3=31.
    localparam logic [19:0] A1 = {5'd31, 5'd9, 5'd7, 5'd3};

    task automatic check_inst1(input string tag, input int first_cyc, input int stall);
        int ea[4] = '{3, 7, 31, 0};
        int ei[4] = '{0, 1, 3, 4};
        int el[4] = '{0, 0, 0, 1};
        check({tag, "_beat_count"}, beat_log.size(), 4);
        for (int i = 0; i < 4; i++) begin
            if (i < beat_log.size()) begin
                check({tag, "_addr"}, beat_log[i].addr, ea[i]);
                check({tag, "_idx"}, beat_log[i].idx, ei[i]);
                check({tag, "_last"}, beat_log[i].last, el[i]);
                check({tag, "_cycle"}, beat_log[i].cyc, first_cyc + i + ((i > 0) ? stall : 0));
            end
        end
        check({tag, "_code_count"}, code_log.size(), 1);
        if (code_log.size() > 0) begin
            check({tag, "_code"}, code_log[0].code, 8'hA5);
            check({tag, "_code_cycle"}, code_log[0].cyc, first_cyc);
        end
    endtask

    initial begin
        int lc;
        int n;
        arst_ni         = 1'b0;
        uinstr_addr_i   = 20'd0;
        uinstr_mask_i   = 4'd0;
        uinstr_pair_i   = 1'b0;
        uinstr_code_i   = 8'd0;
        uinstr_valid_i  = 1'b0;
        rd_addr_ready_i = 1'b1;
        code_ready_i    = 1'b1;
        repeat (3) @(posedge clk_i);
        #1;
        arst_ni = 1'b1;
        @(negedge clk_i);
        check("post_reset_ready", int'(uinstr_ready_o), 1);
        check("post_reset_rd_valid", int'(rd_addr_valid_o), 0);
        @(posedge clk_i);
        #1;

        // 1: mask 1011 with pair, all readies high.
        clear_logs();
        send(A1, 4'b1011, 1'b1, 8'hA5);
        wait_idle();
        if (acc_log.size() > 0) check_inst1("t1", acc_log[0] + 1, 0);
        else check("t1_accept", 0, 1);

        // 2: same instruction, beat ready low for 3 cycles at the second beat.
        clear_logs();
        send(A1, 4'b1011, 1'b1, 8'hA5);
        @(negedge clk_i);
        @(posedge clk_i);
        #1;
        rd_addr_ready_i = 1'b0;
        repeat (3) begin
            @(negedge clk_i);
            check("t2_hold_addr", int'(rd_addr_o), 7);
            check("t2_hold_idx", int'(rd_idx_o), 1);
            check("t2_hold_valid", int'(rd_addr_valid_o), 1);
        end
        @(posedge clk_i);
        #1;
        rd_addr_ready_i = 1'b1;
        wait_idle();
        if (acc_log.size() > 0) check_inst1("t2", acc_log[0] + 1, 3);
        else check("t2_accept", 0, 1);

        // 3: empty mask with pair set: code only.
        clear_logs();
        send(20'd0, 4'b0000, 1'b1, 8'h3C);
        @(negedge clk_i);
        check("t3_ready_on_code", int'(uinstr_ready_o), 1);
        check("t3_code_valid", int'(code_valid_o), 1);
        check("t3_rd_valid", int'(rd_addr_valid_o), 0);
        wait_idle();
        check("t3_beat_count", beat_log.size(), 0);
        check("t3_code_count", code_log.size(), 1);
        if (code_log.size() > 0) check("t3_code", code_log[0].code, 8'h3C);

        // 4: back-to-back instructions.
        clear_logs();
        send(A1, 4'b1011, 1'b1, 8'hA5);
        send({5'd0, 5'd12, 5'd0, 5'd0}, 4'b0100, 1'b0, 8'h11);
        wait_idle();
        check("t4_accepts", acc_log.size(), 2);
        check("t4_beat_count", beat_log.size(), 5);
        if (acc_log.size() == 2 && beat_log.size() == 5) begin
            check("t4_second_accept_cycle", acc_log[1], acc_log[0] + 4);
            check("t4_second_accept_at_last", acc_log[1], beat_log[3].cyc);
            check("t4_b_first_cycle", beat_log[4].cyc, acc_log[1] + 1);
            check("t4_b_addr", beat_log[4].addr, 12);
            check("t4_b_idx", beat_log[4].idx, 2);
            check("t4_b_last", beat_log[4].last, 1);
        end
        check("t4_code_count", code_log.size(), 2);
        if (code_log.size() == 2) check("t4_code_b", code_log[1].code, 8'h11);

        // 5: code channel stalled past the last beat.
        clear_logs();
        code_ready_i = 1'b0;
        send({5'd0, 5'd0, 5'd6, 5'd5}, 4'b0011, 1'b0, 8'h77);
        n = 0;
        do begin
            @(negedge clk_i);
            n++;
        end while (!(rd_addr_valid_o && rd_last_o) && n < 20);
        if (n >= 20) check("t5_last_timeout", 0, 1);
        check("t5_last_addr", int'(rd_addr_o), 6);
        repeat (2) begin
            @(negedge clk_i);
            check("t5_wait_ready", int'(uinstr_ready_o), 0);
            check("t5_wait_rd_valid", int'(rd_addr_valid_o), 0);
            check("t5_wait_code_valid", int'(code_valid_o), 1);
        end
        @(posedge clk_i);
        #1;
        code_ready_i = 1'b1;
        @(negedge clk_i);
        check("t5_ready_on_code", int'(uinstr_ready_o), 1);
        check("t5_code_value", int'(code_o), 8'h77);
        wait_idle();
        check("t5_beat_count", beat_log.size(), 2);

        // 6: reset pulse during the second beat.
        clear_logs();
        send(A1, 4'b1011, 1'b1, 8'h5A);
        @(negedge clk_i);
        @(posedge clk_i);
        #1;
        arst_ni = 1'b0;
        @(negedge clk_i);
        check("t6_rst_ready", int'(uinstr_ready_o), 0);
        check("t6_rst_rd_valid", int'(rd_addr_valid_o), 0);
        check("t6_rst_addr", int'(rd_addr_o), 0);
        @(posedge clk_i);
        #1;
        arst_ni = 1'b1;
        @(negedge clk_i);
        check("t6_after_rd_valid", int'(rd_addr_valid_o), 0);
        check("t6_after_code_valid", int'(code_valid_o), 0);
        check("t6_after_ready", int'(uinstr_ready_o), 1);
        repeat (3) @(negedge clk_i);
        check("t6_beats_before_reset", beat_log.size(), 1);
        check("t6_code_before_reset", code_log.size(), 1);
        @(posedge clk_i);
        #1;
        clear_logs();
        send({5'd0, 5'd0, 5'd0, 5'd20}, 4'b0001, 1'b0, 8'h42);
        wait_idle();
        check("t6_new_beat_count", beat_log.size(), 1);
        if (beat_log.size() > 0) begin
            check("t6_new_addr", beat_log[0].addr, 20);
            check("t6_new_last", beat_log[0].last, 1);
        end
        check("t6_new_code_count", code_log.size(), 1);
        if (code_log.size() > 0) check("t6_new_code", code_log[0].code, 8'h42);

        lc = chk_cnt;
        $display("%0d/%0d checks passed", pass_cnt, lc);
        $finish;
    end

    // Watchdog so a stuck handshake still ends the run.
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

endmodule
